fifo_write_ctrl: RTL

//  Write-domain controller for a dual-clock FIFO. Tracks the binary and Gray

---
 rtl/fifo_write_ctrl_pkg.sv | 21 ++
 rtl/gray_sync_chain.sv | 29 ++
 rtl/fifo_write_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/fifo_write_ctrl_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers (write and read side).
package fifo_write_ctrl_pkg;

   localparam int unsigned DefPtrSz      = 2;
   localparam int unsigned DefSyncStages = 2;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Upper bits beyond the pointer width must be zero for the prefix XOR to be correct.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Plain reset flop chain for crossing a Gray-coded pointer into the local clock domain.
module gray_sync_chain #(
   parameter int unsigned WIDTH  = 3,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-domain controller of a dual-clock FIFO: pointers, full/almost-full, level, overflow.
module fifo_write_ctrl
   import fifo_write_ctrl_pkg::*;
#(
   parameter int unsigned PTR_SZ       = DefPtrSz,
   parameter int unsigned SYNC_STAGES  = DefSyncStages,
   parameter int unsigned AFULL_THRESH = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              winc,
   input  logic [PTR_SZ:0]   rgray,
   input  logic              ovf_clr,
   output logic              write_en,
   output logic [PTR_SZ-1:0] waddr,
   output logic [PTR_SZ:0]   waddr_gray,
   output logic              wfull,
   output logic              walmost_full,
   output logic [PTR_SZ:0]   wlevel,
   output logic              woverflow
);

   localparam int unsigned PW = PTR_SZ + 1;

   // Top two bits set: full when the write Gray pointer equals the read one with those inverted.
   localparam logic [PTR_SZ:0] FullMask = {PW{1'b1}} ^ ({PW{1'b1}} >> 2);

   logic [PTR_SZ:0] wbin_q, wbin_d;
   logic [PTR_SZ:0] gray_q, gray_d;
   logic [PTR_SZ:0] rq_sync, rbin;
   logic [PTR_SZ:0] level_q, level_d;
   logic            full_q, full_d;
   logic            afull_q, afull_d;
   logic            ovf_q, ovf_d;

   gray_sync_chain #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_rptr_sync (
      .clk (clk),
      .rst (rst),
      .d   (rgray),
      .q   (rq_sync)
   );

   always_comb begin
      write_en = winc & ~full_q;
      wbin_d   = wbin_q + PW'(write_en);
      gray_d   = PW'(bin2gray(32'(wbin_d)));
      rbin     = PW'(gray2bin(32'(rq_sync)));
      level_d  = wbin_d - rbin;
      full_d   = (gray_d == (rq_sync ^ FullMask));
      afull_d  = (32'(level_d) >= AFULL_THRESH);
      ovf_d    = ovf_q;
      if (winc && full_q) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wbin_q  <= '0;
         gray_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         gray_q  <= gray_d;
         level_q <= level_d;
         full_q  <= full_d;
         afull_q <= afull_d;
         ovf_q   <= ovf_d;
      end
   end

   assign waddr        = wbin_q[PTR_SZ-1:0];
   assign waddr_gray   = gray_q;
   assign wfull        = full_q;
   assign walmost_full = afull_q;
   assign wlevel       = level_q;
   assign woverflow    = ovf_q;

endmodule
